// File: rtl/dac_seq_pkg.sv
// Shared types, constants and the offset-binary conversion for the DAC sequencer.
package dac_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_START     = 2'd1,
    ST_WAIT_ACK  = 2'd2,
    ST_WAIT_DONE = 2'd3
  } dac_state_e;

  localparam logic [15:0]  DAC_MID = 16'h8000;
  localparam int unsigned  ALIGN_W = 32;

  // Input is the sample left-aligned in ALIGN_W bits; result is the top dac_w
  // bits in offset binary, right-justified. Truncates, no rounding.
  function automatic logic [ALIGN_W-1:0] to_offset_bin(input logic [ALIGN_W-1:0] left_aligned,
                                                       input int unsigned        dac_w);
    logic [ALIGN_W-1:0] flipped;
    flipped = left_aligned ^ {1'b1, {(ALIGN_W-1){1'b0}}};
    return flipped >> (ALIGN_W - dac_w);
  endfunction

endpackage

// File: rtl/dac_sequencer_wait_timer.sv
// Handshake phase timer: clears on request, counts while enabled, flags TIMEOUT_CYC cycles.
module wait_timer #(
  parameter int unsigned TIMEOUT_CYC = 1024
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic clear_i,
  input  logic enable_i,
  output logic expired_c
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC + 1);

  logic [CNT_W-1:0] count_q, count_d;

  assign expired_c = enable_i && (count_q == CNT_W'(TIMEOUT_CYC - 1));

  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (enable_i && !expired_c) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/dac_sequencer.sv
// Two-channel DAC write sequencer: latches a filter tick and drives the shared DAC writer.
// Optional handshake timeout enabled by defining DAC_SEQ_TIMEOUT_EN.
module dac_sequencer
  import dac_seq_pkg::*;
#(
  parameter int unsigned DATA_W      = 24,
  parameter int unsigned DAC_W       = 16,
  parameter int unsigned TIMEOUT_CYC = 1024
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              tick_i,
  input  logic [DATA_W-1:0] ch1_i,
  input  logic [DATA_W-1:0] ch2_i,
  input  logic [1:0]        enable_i,
  input  logic              dac_busy_i,
  output logic              dac_start_o,
  output logic [DAC_W-1:0]  dac_data_o,
  output logic              dac_addr_o,
  output logic              busy_o,
  output logic              frame_done_o,
  output logic [7:0]        overrun_cnt_o,
  output logic              timeout_o
);

  localparam int unsigned PAD_W = ALIGN_W - DATA_W;
  localparam logic [DAC_W-1:0] DAC_RST = DAC_W'({DAC_MID, 16'h0000} >> (ALIGN_W - DAC_W));

  dac_state_e        state_q, state_d;
  logic [DATA_W-1:0] ch1_q, ch1_d, ch2_q, ch2_d;
  logic [1:0]        en_q, en_d;
  logic              chan_q, chan_d;
  logic              start_q, start_d;
  logic [DAC_W-1:0]  data_q, data_d;
  logic              addr_q, addr_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [7:0]        ovr_q, ovr_d;
  logic              timeout_q, timeout_d;
  logic              phase_end_c;
  logic              tmo_expired_c;
  logic [DATA_W-1:0] next_sample_c;

`ifdef DAC_SEQ_TIMEOUT_EN
  logic tmr_en_c, tmr_clear_c;

  assign tmr_en_c    = (state_q == ST_WAIT_ACK) || (state_q == ST_WAIT_DONE);
  assign tmr_clear_c = (state_d != state_q);

  wait_timer #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_wait_timer (
    .clk_i     (clk_i),
    .reset_i   (reset_i),
    .clear_i   (tmr_clear_c),
    .enable_i  (tmr_en_c),
    .expired_c (tmo_expired_c)
  );
`else
  // No timer in this build: handshakes wait forever; TIMEOUT_CYC kept referenced.
  assign tmo_expired_c = 1'b0 & (TIMEOUT_CYC == 0);
`endif

  // Next-state, frame bookkeeping and registered-output values.
  always_comb begin
    state_d       = state_q;
    ch1_d         = ch1_q;
    ch2_d         = ch2_q;
    en_d          = en_q;
    chan_d        = chan_q;
    data_d        = data_q;
    addr_d        = addr_q;
    done_d        = 1'b0;
    ovr_d         = ovr_q;
    timeout_d     = timeout_q | tmo_expired_c;
    phase_end_c   = 1'b0;
    next_sample_c = '0;

    case (state_q)
      ST_IDLE: begin
        if (tick_i && (enable_i != 2'b00)) begin
          ch1_d   = ch1_i;
          ch2_d   = ch2_i;
          en_d    = enable_i;
          chan_d  = ~enable_i[0];
          state_d = ST_START;
        end
      end
      ST_START:     state_d = ST_WAIT_ACK;
      ST_WAIT_ACK: begin
        if (dac_busy_i) begin
          state_d = ST_WAIT_DONE;
        end else if (tmo_expired_c) begin
          phase_end_c = 1'b1;
        end
      end
      ST_WAIT_DONE: phase_end_c = !dac_busy_i || tmo_expired_c;
      default:      state_d = ST_IDLE;
    endcase

    // Channel finished (or abandoned): ch2 follows ch1 only if latched-enabled.
    if (phase_end_c) begin
      if (!chan_q && en_q[1]) begin
        chan_d  = 1'b1;
        state_d = ST_START;
      end else begin
        state_d = ST_IDLE;
        done_d  = 1'b1;
      end
    end

    if (tick_i && (state_q != ST_IDLE) && (ovr_q != 8'hFF)) begin
      ovr_d = ovr_q + 8'd1;
    end

    start_d = (state_d == ST_START);
    busy_d  = (state_d != ST_IDLE);
    if (state_d == ST_START) begin
      next_sample_c = chan_d ? ch2_d : ch1_d;
      data_d        = DAC_W'(to_offset_bin(ALIGN_W'(next_sample_c) << PAD_W, DAC_W));
      addr_d        = chan_d;
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q   <= ST_IDLE;
      ch1_q     <= '0;
      ch2_q     <= '0;
      en_q      <= 2'b00;
      chan_q    <= 1'b0;
      start_q   <= 1'b0;
      data_q    <= DAC_RST;
      addr_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      ovr_q     <= 8'd0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ch1_q     <= ch1_d;
      ch2_q     <= ch2_d;
      en_q      <= en_d;
      chan_q    <= chan_d;
      start_q   <= start_d;
      data_q    <= data_d;
      addr_q    <= addr_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      ovr_q     <= ovr_d;
      timeout_q <= timeout_d;
    end
  end

  assign dac_start_o   = start_q;
  assign dac_data_o    = data_q;
  assign dac_addr_o    = addr_q;
  assign busy_o        = busy_q;
  assign frame_done_o  = done_q;
  assign overrun_cnt_o = ovr_q;
  assign timeout_o     = timeout_q;

endmodule
